pixel_write_arbiter: RTL and testbench

// Downstream of the parallel pixel-computation cores: collects the per-core pixel write

---
 rtl/pixel_write_arbiter_pkg.sv | 27 ++
 rtl/pixel_write_arbiter_if.sv | 13 +
 rtl/pixel_write_arbiter_fifo.sv | 49 ++++
 rtl/pixel_write_arbiter.sv | 111 +++++++++++
 tb/tb_pixel_write_arbiter.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/pixel_write_arbiter_pkg.sv
// rtl/pixel_write_arbiter_pkg.sv - shared widths, lane entry type and arbiter state encoding
package pixel_write_arbiter_pkg;

    localparam int CORES_COUNT   = 10;
    localparam int COLOR_WIDTH   = 16;
    localparam int BUFFER_ADDR_W = 32;
    localparam int FIFO_DEPTH    = 8;

    typedef struct packed {
        logic [BUFFER_ADDR_W-1:0] addr;
        logic [COLOR_WIDTH-1:0]   data;
    } pixel_wr_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } arb_state_t;

    // Pixel index to framebuffer byte address; wraps modulo 2^BUFFER_ADDR_W.
    function automatic logic [BUFFER_ADDR_W-1:0] byte_addr(
        input logic [BUFFER_ADDR_W-1:0] base,
        input logic [BUFFER_ADDR_W-1:0] index
    );
        return base + index * BUFFER_ADDR_W'(COLOR_WIDTH / 8);
    endfunction

endpackage

// File: rtl/pixel_write_arbiter_if.sv
// rtl/pixel_write_arbiter_if.sv - Avalon-MM write-only master bus toward the framebuffer
interface pixel_write_arbiter_if;
    import pixel_write_arbiter_pkg::*;

    logic [BUFFER_ADDR_W-1:0] address;
    logic [COLOR_WIDTH-1:0]   writedata;
    logic                     write;
    logic                     waitrequest;

    modport master (output address, writedata, write, input waitrequest);
    modport slave  (input address, writedata, write, output waitrequest);

endinterface

// File: rtl/pixel_write_arbiter_fifo.sv
// rtl/pixel_write_arbiter_fifo.sv - single-clock show-ahead lane FIFO of pixel writes
module pixel_write_arbiter_fifo
    import pixel_write_arbiter_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic      clk,
    input  logic      reset_n,
    input  logic      push,
    input  pixel_wr_t wdata,
    input  logic      pop,
    output pixel_wr_t rdata,
    output logic      full,
    output logic      empty
);

    localparam int PTR_W = $clog2(DEPTH);

    pixel_wr_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/pixel_write_arbiter.sv
// rtl/pixel_write_arbiter.sv - buffers per-core pixel lanes and serialises them round-robin
// onto one Avalon-MM write master into the framebuffer.
module pixel_write_arbiter
    import pixel_write_arbiter_pkg::*;
#(
    parameter logic [BUFFER_ADDR_W-1:0] FB_BASE = '0
) (
    input  logic                                        clk,
    input  logic                                        reset_n,
    input  logic [CORES_COUNT-1:0][COLOR_WIDTH-1:0]     in_data,
    input  logic [CORES_COUNT-1:0][BUFFER_ADDR_W-1:0]   in_addr,
    input  logic [CORES_COUNT-1:0]                      in_valid,
    input  logic                                        clear_err,
    output logic [CORES_COUNT-1:0]                      overflow,
    output logic                                        idle,
    pixel_write_arbiter_if.master                       avm
);

    localparam int PTR_W = $clog2(CORES_COUNT);

    logic [CORES_COUNT-1:0]   full;
    logic [CORES_COUNT-1:0]   empty;
    logic [CORES_COUNT-1:0]   pop;
    logic [CORES_COUNT-1:0]   drop;
    pixel_wr_t                head [CORES_COUNT];

    arb_state_t               state;
    arb_state_t               next_state;
    logic [PTR_W-1:0]         rr_ptr;
    logic [PTR_W-1:0]         grant;
    logic [PTR_W-1:0]         next_rr;
    logic                     found;
    logic                     can_load;
    logic                     load;
    logic [BUFFER_ADDR_W-1:0] address_r;
    logic [COLOR_WIDTH-1:0]   writedata_r;

    for (genvar g = 0; g < CORES_COUNT; g++) begin : g_lane
        pixel_wr_t entry;
        assign entry   = '{addr: in_addr[g], data: in_data[g]};
        assign drop[g] = in_valid[g] && full[g] && !pop[g];

        pixel_write_arbiter_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk     (clk),
            .reset_n (reset_n),
            .push    (in_valid[g]),
            .wdata   (entry),
            .pop     (pop[g]),
            .rdata   (head[g]),
            .full    (full[g]),
            .empty   (empty[g])
        );
    end

    always_comb begin
        int idx;
        idx        = 0;
        found      = 1'b0;
        grant      = '0;
        pop        = '0;
        next_state = state;
        // Search from rr_ptr upward, wrapping, for the first lane with data.
        for (int k = 0; k < CORES_COUNT; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= CORES_COUNT) idx = idx - CORES_COUNT;
            if (!found && !empty[idx]) begin
                found = 1'b1;
                grant = PTR_W'(idx);
            end
        end
        can_load = (state == ST_IDLE) || !avm.waitrequest;
        load     = can_load && found;
        next_rr  = (grant == PTR_W'(CORES_COUNT - 1)) ? '0 : grant + PTR_W'(1);
        if (load) pop[grant] = 1'b1;
        if (can_load) next_state = found ? ST_WRITE : ST_IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            rr_ptr      <= '0;
            address_r   <= '0;
            writedata_r <= '0;
        end else begin
            state <= next_state;
            if (load) begin
                rr_ptr      <= next_rr;
                address_r   <= byte_addr(FB_BASE, head[grant].addr);
                writedata_r <= head[grant].data;
            end
        end
    end

    // A new drop outranks clear_err so no loss goes unreported.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= '0;
        end else begin
            for (int i = 0; i < CORES_COUNT; i++) begin
                if (drop[i])        overflow[i] <= 1'b1;
                else if (clear_err) overflow[i] <= 1'b0;
            end
        end
    end

    assign avm.address   = address_r;
    assign avm.writedata = writedata_r;
    assign avm.write     = (state == ST_WRITE);
    assign idle          = (&empty) && (state == ST_IDLE);

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// tb/tb_pixel_write_arbiter.sv - directed self-checking bench for pixel_write_arbiter
module tb_pixel_write_arbiter;
    import pixel_write_arbiter_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [CORES_COUNT-1:0][COLOR_WIDTH-1:0]   in_data;
    logic [CORES_COUNT-1:0][BUFFER_ADDR_W-1:0] in_addr;
    logic [CORES_COUNT-1:0]                    in_valid;
    logic                                      clear_err;
    logic [CORES_COUNT-1:0]                    overflow;
    logic                                      idle;

    pixel_write_arbiter_if avm_bus ();

    pixel_write_arbiter #(.FB_BASE(32'h0)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_data   (in_data),
        .in_addr   (in_addr),
        .in_valid  (in_valid),
        .clear_err (clear_err),
        .overflow  (overflow),
        .idle      (idle),
        .avm       (avm_bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cycle = 0;
    logic [31:0] log_addr [$];
    logic [15:0] log_data [$];
    int          log_cyc  [$];

    always @(posedge clk) begin
        cycle <= cycle + 1;
        if (reset_n && avm_bus.write === 1'b1 && avm_bus.waitrequest === 1'b0) begin
            log_addr.push_back(avm_bus.address);
            log_data.push_back(avm_bus.writedata);
            log_cyc.push_back(cycle);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        log_cyc.delete();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step(2);
        reset_n = 1'b1;
        step(1);
    endtask

    task automatic check_entry(input string tag, input int i, input logic [31:0] ea, input logic [15:0] ed);
        logic [31:0] oa;
        logic [15:0] od;
        oa = (i < log_addr.size()) ? log_addr[i] : 'x;
        od = (i < log_data.size()) ? log_data[i] : 'x;
        check($sformatf("%s_addr[%0d]", tag, i), 64'(oa), 64'(ea));
        check($sformatf("%s_data[%0d]", tag, i), 64'(od), 64'(ed));
    endtask

    initial begin
        in_valid = '0;
        in_data = '0;
        in_addr = '0;
        clear_err = 1'b0;
        avm_bus.waitrequest = 1'b0;
        step(2);
        reset_n = 1'b1;
        step(1);

        check("rst_write", 64'(avm_bus.write), 64'(0));
        check("rst_address", 64'(avm_bus.address), 64'(0));
        check("rst_writedata", 64'(avm_bus.writedata), 64'(0));
        check("rst_overflow", 64'(overflow), 64'(0));
        check("rst_idle", 64'(idle), 64'(1));

        // Single pixel on lane 0
        clear_log();
        in_valid[0] = 1'b1; in_addr[0] = 32'd5; in_data[0] = 16'hABCD;
        step(1);
        in_valid = '0;
        check("single_latency_write", 64'(avm_bus.write), 64'(0));
        step(1);
        check("single_write", 64'(avm_bus.write), 64'(1));
        check("single_address", 64'(avm_bus.address), 64'(10));
        check("single_data", 64'(avm_bus.writedata), 64'(16'hABCD));
        check("single_busy", 64'(idle), 64'(0));
        step(1);
        check("single_write_drop", 64'(avm_bus.write), 64'(0));
        check("single_idle", 64'(idle), 64'(1));
        check("single_count", 64'(log_addr.size()), 64'(1));

        // All lanes at once, no stall
        do_reset();
        clear_log();
        for (int i = 0; i < CORES_COUNT; i++) begin
            in_valid[i] = 1'b1; in_addr[i] = 32'(i); in_data[i] = 16'h1000 + 16'(i);
        end
        step(1);
        in_valid = '0;
        step(12);
        check("all_count", 64'(log_addr.size()), 64'(10));
        for (int i = 0; i < CORES_COUNT; i++) begin
            check_entry("all", i, 32'(2 * i), 16'h1000 + 16'(i));
            check($sformatf("all_b2b[%0d]", i),
                  64'((i < log_cyc.size() && log_cyc.size() > 0) ? log_cyc[i] - log_cyc[0] : -1), 64'(i));
        end
        check("all_idle", 64'(idle), 64'(1));

        // All lanes with a 3-cycle stall on the first write
        clear_log();
        avm_bus.waitrequest = 1'b1;
        for (int i = 0; i < CORES_COUNT; i++) begin
            in_valid[i] = 1'b1; in_addr[i] = 32'(i); in_data[i] = 16'h1000 + 16'(i);
        end
        step(1);
        in_valid = '0;
        step(1);
        for (int s = 0; s < 4; s++) begin
            check($sformatf("stall_write[%0d]", s), 64'(avm_bus.write), 64'(1));
            check($sformatf("stall_address[%0d]", s), 64'(avm_bus.address), 64'(0));
            check($sformatf("stall_data[%0d]", s), 64'(avm_bus.writedata), 64'(16'h1000));
            if (s == 3) avm_bus.waitrequest = 1'b0;
            step(1);
        end
        step(12);
        check("stall_count", 64'(log_addr.size()), 64'(10));
        for (int i = 0; i < CORES_COUNT; i++) check_entry("stall", i, 32'(2 * i), 16'h1000 + 16'(i));

        // Overflow on lane 2 with the slave stalled
        clear_log();
        avm_bus.waitrequest = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            if (k == 9) check("ovf_before_full", 64'(overflow), 64'(0));
            if (k == 10) begin
                check("ovf_first_drop", 64'(overflow), 64'(10'b0000000100));
                clear_err = 1'b1;
            end
            in_valid[2] = 1'b1; in_addr[2] = 32'(100 + k); in_data[2] = 16'(k);
            step(1);
        end
        check("ovf_drop_beats_clear", 64'(overflow), 64'(10'b0000000100));
        in_valid = '0;
        step(1);
        check("ovf_cleared", 64'(overflow), 64'(0));
        clear_err = 1'b0;
        check("ovf_hold_address", 64'(avm_bus.address), 64'(200));
        check("ovf_hold_data", 64'(avm_bus.writedata), 64'(0));
        avm_bus.waitrequest = 1'b0;
        step(12);
        check("ovf_count", 64'(log_addr.size()), 64'(9));
        for (int k = 0; k < 9; k++) check_entry("ovf", k, 32'(200 + 2 * k), 16'(k));
        check("ovf_idle", 64'(idle), 64'(1));

        // Lanes 3 and 7 streaming together
        do_reset();
        clear_log();
        for (int k = 0; k < 8; k++) begin
            in_valid[3] = 1'b1; in_addr[3] = 32'(300 + k); in_data[3] = 16'h0300 + 16'(k);
            in_valid[7] = 1'b1; in_addr[7] = 32'(700 + k); in_data[7] = 16'h0700 + 16'(k);
            step(1);
        end
        in_valid = '0;
        step(20);
        check("rr_count", 64'(log_addr.size()), 64'(16));
        for (int j = 0; j < 16; j++) begin
            int lane;
            lane = (j % 2 == 0) ? 3 : 7;
            check_entry("rr", j, 32'(2 * (lane * 100 + j / 2)), 16'(lane * 256 + j / 2));
        end
        check("rr_overflow", 64'(overflow), 64'(0));

        // Reset in the middle of a stalled transfer
        clear_log();
        avm_bus.waitrequest = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid[i] = 1'b1; in_addr[i] = 32'(50 + i); in_data[i] = 16'h2000 + 16'(i);
        end
        step(1);
        in_valid = '0;
        step(1);
        check("abort_write_before", 64'(avm_bus.write), 64'(1));
        #2 reset_n = 1'b0;
        #1 check("abort_write_async", 64'(avm_bus.write), 64'(0));
        step(2);
        reset_n = 1'b1;
        avm_bus.waitrequest = 1'b0;
        step(10);
        check("abort_idle", 64'(idle), 64'(1));
        check("abort_write_after", 64'(avm_bus.write), 64'(0));
        check("abort_no_writes", 64'(log_addr.size()), 64'(0));
        in_valid[1] = 1'b1; in_addr[1] = 32'd7; in_data[1] = 16'h5A5A;
        step(1);
        in_valid = '0;
        step(3);
        check("abort_new_count", 64'(log_addr.size()), 64'(1));
        check_entry("abort_new", 0, 32'd14, 16'h5A5A);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
